// File: rtl/note_recorder.sv
// note_recorder
// Captures a player-entered note sequence from the four note keys. It packs
// the notes into the 48-bit level word used by the playback and response
// engines.
//
// Each accepted note k fills the upper nibble of byte k, counting from the
// MSB end. The lower nibble of that byte stays 0 and forms the gap slot.
// level_length counts slots, so it advances by 2 per note.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   start_record   begin a new recording (from IDLE or DONE)
//   stop_record    end the recording early
//   note_inputs    active-high key levels, one bit per note
//   level_data     recorded level word
//   level_length   slot count (2 x notes recorded)
//   recording      high while a recording is in progress
//   done_record    one-cycle pulse on entry to DONE
//   invalid_press  one-cycle pulse when a debounced press is not one-hot
module note_recorder #(
    parameter int MAX_NOTES       = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_record,
    input  logic        stop_record,
    input  logic [3:0]  note_inputs,
    output logic [47:0] level_data,
    output logic [3:0]  level_length,
    output logic        recording,
    output logic        done_record,
    output logic        invalid_press
);

    localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   DB_LOAD  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      MAX_CNT  = 3'(MAX_NOTES);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] ARMED        = 3'd1;
    localparam logic [2:0] WAIT_PRESS   = 3'd2;
    localparam logic [2:0] DEBOUNCE     = 3'd3;
    localparam logic [2:0] WAIT_RELEASE = 3'd4;
    localparam logic [2:0] DONE         = 3'd5;

    logic [2:0]    state;
    logic [2:0]    count;
    logic [CW-1:0] db_cnt;
    logic [3:0]    sample;

    assign recording = (state == ARMED) || (state == WAIT_PRESS) ||
                       (state == DEBOUNCE) || (state == WAIT_RELEASE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            level_data    <= '0;
            level_length  <= '0;
            count         <= '0;
            db_cnt        <= '0;
            sample        <= '0;
            done_record   <= 1'b0;
            invalid_press <= 1'b0;
        end else begin
            done_record   <= 1'b0;
            invalid_press <= 1'b0;
            case (state)
                // Start outranks stop here; stop alone does nothing.
                IDLE, DONE: begin
                    if (start_record) begin
                        level_data   <= '0;
                        level_length <= '0;
                        count        <= '0;
                        state        <= ARMED;
                    end
                end
                // Hold off until every key is up so a key still held from
                // the start action is not captured as the first note.
                ARMED: begin
                    if (stop_record) begin
                        state       <= DONE;
                        done_record <= 1'b1;
                    end else if (note_inputs == 4'b0000) begin
                        state <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (stop_record) begin
                        state       <= DONE;
                        done_record <= 1'b1;
                    end else if (note_inputs != 4'b0000) begin
                        sample <= note_inputs;
                        db_cnt <= DB_LOAD;
                        state  <= DEBOUNCE;
                    end
                end
                // Stop is tested first, so it outranks acceptance in the same cycle.
                DEBOUNCE: begin
                    if (stop_record) begin
                        state       <= DONE;
                        done_record <= 1'b1;
                    end else if (note_inputs != sample) begin
                        state <= WAIT_PRESS;
                    end else if (db_cnt == '0) begin
                        if ($onehot(sample)) begin
                            for (int k = 0; k < MAX_NOTES; k++) begin
                                if (count == 3'(k))
                                    level_data[47-8*k -: 4] <= sample;
                            end
                            count        <= count + 3'd1;
                            level_length <= level_length + 4'd2;
                        end else begin
                            invalid_press <= 1'b1;
                        end
                        state <= WAIT_RELEASE;
                    end else begin
                        db_cnt <= db_cnt - 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (stop_record) begin
                        state       <= DONE;
                        done_record <= 1'b1;
                    end else if (note_inputs == 4'b0000) begin
                        if (count == MAX_CNT) begin
                            state       <= DONE;
                            done_record <= 1'b1;
                        end else begin
                            state <= WAIT_PRESS;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder
// Directed, table-driven bench for note_recorder. Each table row drives the
// inputs for a number of cycles and then checks the outputs. The outputs
// checked are level_data, level_length, recording, and the running counts of
// done_record and invalid_press pulses. Hand-written sequences cover the
// exact acceptance latency and an asynchronous reset taken mid-debounce.
module tb_note_recorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_record, stop_record;
    logic [3:0]  note_inputs;
    logic [47:0] level_data;
    logic [3:0]  level_length;
    logic        recording, done_record, invalid_press;

    note_recorder #(.MAX_NOTES(6), .DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_record  (start_record),
        .stop_record   (stop_record),
        .note_inputs   (note_inputs),
        .level_data    (level_data),
        .level_length  (level_length),
        .recording     (recording),
        .done_record   (done_record),
        .invalid_press (invalid_press)
    );

    always #5 clk = ~clk;

    // Pulse counters. Each pulse is high for one full cycle, so it is seen at
    // exactly one falling edge.
    int done_cnt = 0;
    int inv_cnt  = 0;
    always @(negedge clk) begin
        if (done_record)   done_cnt++;
        if (invalid_press) inv_cnt++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic        sp;
        logic [3:0]  n;
        int          cyc;
        logic [47:0] e_data;
        logic [3:0]  e_len;
        logic        e_rec;
        int          e_done;
        int          e_inv;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, input logic sp, input logic [3:0] n, input int cyc,
                       input logic [47:0] d, input logic [3:0] l, input logic r,
                       input int dn, input int iv);
        vec_t v;
        v.st = st; v.sp = sp; v.n = n; v.cyc = cyc;
        v.e_data = d; v.e_len = l; v.e_rec = r; v.e_done = dn; v.e_inv = iv;
        vq.push_back(v);
    endtask

    // Inputs change at negedge+1; outputs are checked at negedge+1, clear of
    // the rising edge.
    task automatic step(input logic st, input logic sp, input logic [3:0] n, input int cyc);
        start_record = st;
        stop_record  = sp;
        note_inputs  = n;
        repeat (cyc) @(negedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [47:0] d, input logic [3:0] l,
                             input logic r, input int dn, input int iv);
        check({tag, ".data"}, level_data, d);
        check({tag, ".len"},  48'(level_length), 48'(l));
        check({tag, ".rec"},  48'(recording), 48'(r));
        check({tag, ".done"}, 48'(done_cnt), 48'(dn));
        check({tag, ".inv"},  48'(inv_cnt), 48'(iv));
    endtask

    initial begin
        reset = 1'b1; start_record = 1'b0; stop_record = 1'b0; note_inputs = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        check_all("reset", 48'h0, 4'd0, 1'b0, 0, 0);
        reset = 1'b0;

        // Test 1: two notes, then stop.
        add(1,0,4'h0,1, 48'h0,            0, 1, 0, 0);
        add(0,0,4'h0,1, 48'h0,            0, 1, 0, 0);
        add(0,0,4'h1,6, 48'h100000000000, 2, 1, 0, 0);
        add(0,0,4'h0,2, 48'h100000000000, 2, 1, 0, 0);
        add(0,0,4'h4,6, 48'h104000000000, 4, 1, 0, 0);
        add(0,0,4'h0,2, 48'h104000000000, 4, 1, 0, 0);
        add(0,1,4'h0,1, 48'h104000000000, 4, 0, 1, 0);
        add(0,0,4'h0,3, 48'h104000000000, 4, 0, 1, 0);
        // Test 2: six notes, auto-finish on the sixth release, then an ignored press.
        add(1,0,4'h0,1, 48'h0,            0, 1, 1, 0);
        add(0,0,4'h0,1, 48'h0,            0, 1, 1, 0);
        add(0,0,4'h1,6, 48'h100000000000, 2, 1, 1, 0);
        add(0,0,4'h0,2, 48'h100000000000, 2, 1, 1, 0);
        add(0,0,4'h2,6, 48'h102000000000, 4, 1, 1, 0);
        add(0,0,4'h0,2, 48'h102000000000, 4, 1, 1, 0);
        add(0,0,4'h4,6, 48'h102040000000, 6, 1, 1, 0);
        add(0,0,4'h0,2, 48'h102040000000, 6, 1, 1, 0);
        add(0,0,4'h8,6, 48'h102040800000, 8, 1, 1, 0);
        add(0,0,4'h0,2, 48'h102040800000, 8, 1, 1, 0);
        add(0,0,4'h1,6, 48'h102040801000,10, 1, 1, 0);
        add(0,0,4'h0,2, 48'h102040801000,10, 1, 1, 0);
        add(0,0,4'h2,6, 48'h102040801020,12, 1, 1, 0);
        add(0,0,4'h0,2, 48'h102040801020,12, 0, 2, 0);
        add(0,0,4'h4,6, 48'h102040801020,12, 0, 2, 0);
        add(0,0,4'h0,2, 48'h102040801020,12, 0, 2, 0);
        // Test 3: glitch then a clean press.
        add(1,0,4'h0,1, 48'h0,            0, 1, 2, 0);
        add(0,0,4'h0,1, 48'h0,            0, 1, 2, 0);
        add(0,0,4'h2,2, 48'h0,            0, 1, 2, 0);
        add(0,0,4'h0,1, 48'h0,            0, 1, 2, 0);
        add(0,0,4'h2,6, 48'h200000000000, 2, 1, 2, 0);
        add(0,0,4'h0,2, 48'h200000000000, 2, 1, 2, 0);
        add(0,1,4'h0,1, 48'h200000000000, 2, 0, 3, 0);
        // Test 4: a chord is rejected; the next valid press lands in slot 0.
        add(1,0,4'h0,1, 48'h0,            0, 1, 3, 0);
        add(0,0,4'h0,1, 48'h0,            0, 1, 3, 0);
        add(0,0,4'h3,6, 48'h0,            0, 1, 3, 1);
        add(0,0,4'h0,2, 48'h0,            0, 1, 3, 1);
        add(0,0,4'h8,6, 48'h800000000000, 2, 1, 3, 1);
        add(0,0,4'h0,2, 48'h800000000000, 2, 1, 3, 1);
        add(0,1,4'h0,1, 48'h800000000000, 2, 0, 4, 1);
        // Test 5: key held through start stays ARMED until released.
        add(1,0,4'h4,1, 48'h0,            0, 1, 4, 1);
        add(0,0,4'h4,6, 48'h0,            0, 1, 4, 1);
        add(0,0,4'h0,1, 48'h0,            0, 1, 4, 1);
        add(0,0,4'h1,6, 48'h100000000000, 2, 1, 4, 1);
        add(0,0,4'h0,2, 48'h100000000000, 2, 1, 4, 1);
        // start is ignored while recording; stop wins over start while recording.
        add(1,0,4'h0,2, 48'h100000000000, 2, 1, 4, 1);
        add(1,1,4'h0,1, 48'h100000000000, 2, 0, 5, 1);
        // start wins over stop in DONE; stop with nothing recorded gives an empty level.
        add(1,1,4'h0,1, 48'h0,            0, 1, 5, 1);
        add(0,1,4'h0,1, 48'h0,            0, 0, 6, 1);
        add(0,0,4'h0,2, 48'h0,            0, 0, 6, 1);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].st, vq[i].sp, vq[i].n, vq[i].cyc);
            check_all($sformatf("vec%0d", i), vq[i].e_data, vq[i].e_len, vq[i].e_rec,
                      vq[i].e_done, vq[i].e_inv);
        end

        // Acceptance latency: a press seen at 4 rising edges is dropped;
        // one seen at 5 is recorded.
        step(1, 0, 4'h0, 1);
        step(0, 0, 4'h0, 1);
        step(0, 0, 4'h8, 4);
        step(0, 0, 4'h0, 1);
        check("lat_short.len", 48'(level_length), 48'd0);
        step(0, 0, 4'h8, 4);
        check("lat_4edge.len", 48'(level_length), 48'd0);
        step(0, 0, 4'h8, 1);
        check("lat_5edge.len", 48'(level_length), 48'd2);
        check("lat_5edge.data", level_data, 48'h800000000000);
        step(0, 0, 4'h0, 2);

        // Second note, then reset asynchronously during the third debounce.
        step(0, 0, 4'h1, 6);
        check("two.len", 48'(level_length), 48'd4);
        step(0, 0, 4'h0, 2);
        step(0, 0, 4'h2, 2);
        reset = 1'b1;
        #1;
        check("arst.data", level_data, 48'h0);
        check("arst.len",  48'(level_length), 48'd0);
        check("arst.rec",  48'(recording), 48'd0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 4'h0, 3);
        check("idle_stop.done", 48'(done_cnt), 48'd6);
        check("idle_stop.rec",  48'(recording), 48'd0);
        check("idle_stop.inv",  48'(inv_cnt), 48'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
